fir_out_uart_tx: RTL and testbench

//   Serializer stage downstream of the FIR/coefficient-control block.

---
 rtl/fir_out_uart_tx_if.sv | 32 +++
 rtl/fir_out_uart_tx.sv | 128 ++++++++++++
 tb/tb_fir_out_uart_tx.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/fir_out_uart_tx_if.sv
// rtl/fir_out_uart_tx_if.sv - sample-in / UART-out signal bundle for fir_out_uart_tx
// Purpose: groups the sample strobe, send gate and UART/status outputs.
// Signals:
//   dato_i        16  FIR output sample (two's complement, sent raw)
//   dato_valid_i  1   one-cycle strobe, dato_i valid this cycle
//   send_i        1   level enable for accepting new samples
//   tx_o          1   UART line, idle high
//   busy_o        1   frame in progress
//   done_o        1   one-cycle pulse on frame completion
//   overrun_o     1   sticky dropped-sample flag
// Modports: master drives the sample side, slave is the serializer.
interface fir_out_uart_tx_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] dato_i;
  logic              dato_valid_i;
  logic              send_i;
  logic              tx_o;
  logic              busy_o;
  logic              done_o;
  logic              overrun_o;

  modport master (
    output dato_i, dato_valid_i, send_i,
    input  tx_o, busy_o, done_o, overrun_o
  );

  modport slave (
    input  dato_i, dato_valid_i, send_i,
    output tx_o, busy_o, done_o, overrun_o
  );
endinterface

// File: rtl/fir_out_uart_tx.sv
// rtl/fir_out_uart_tx.sv - 16-bit FIR sample to two 8N1 UART bytes, MSB byte first
// Purpose: latches one FIR output sample and serializes it as two back-to-back
//   8N1 bytes (high byte first, each byte LSB first), gated by send_i.
// Ports:
//   clk_100MHz_i  in   system clock, rising edge
//   rst_n_i       in   asynchronous active-low reset
//   bus           slave modport of fir_out_uart_tx_if (sample in, UART/status out)
module fir_out_uart_tx #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD        = 115200,
  parameter int DATA_W      = 16
) (
  input  logic              clk_100MHz_i,
  input  logic              rst_n_i,
  fir_out_uart_tx_if.slave  bus
);

  localparam int              CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int              CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  baud_cnt;
  logic [2:0]        bit_cnt;
  logic              byte_idx;
  logic [DATA_W-1:0] shreg;
  logic              tx;
  logic              busy;
  logic              done;
  logic              overrun;

  logic              bit_end;
  logic [2:0]        bit_nxt;

  assign bit_end = (baud_cnt == CNT_LAST);
  assign bit_nxt = bit_cnt + 3'd1;

  assign bus.tx_o      = tx;
  assign bus.busy_o    = busy;
  assign bus.done_o    = done;
  assign bus.overrun_o = overrun;

  // Bit select into the sample: byte_idx 0 addresses [15:8], 1 addresses [7:0],
  // so the upper index bit is simply ~byte_idx.
  always_ff @(posedge clk_100MHz_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_idx <= 1'b0;
      shreg    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      done <= 1'b0;

      // busy is low in the done cycle, so a strobe there is accepted, not dropped.
      if (bus.dato_valid_i && busy) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.dato_valid_i && bus.send_i) begin
            shreg    <= bus.dato_i;
            state    <= START;
            tx       <= 1'b0;
            busy     <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            byte_idx <= 1'b0;
          end
        end

        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= DATA;
            tx       <= shreg[{~byte_idx, 3'd0}];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_cnt <= bit_nxt;
              tx      <= shreg[{~byte_idx, bit_nxt}];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (!byte_idx) begin
              // Second byte follows with no idle gap.
              byte_idx <= 1'b1;
              state    <= START;
              tx       <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_out_uart_tx.sv
// tb/tb_fir_out_uart_tx.sv - self-checking bench for fir_out_uart_tx
module tb_fir_out_uart_tx;

  localparam int CPB   = 100000000 / 115200;
  localparam int FRAME = 20 * CPB;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  fir_out_uart_tx_if bus ();

  fir_out_uart_tx dut (
    .clk_100MHz_i (clk),
    .rst_n_i      (rst_n),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [15:0] d);
    bus.dato_i       = d;
    bus.dato_valid_i = 1'b1;
    @(negedge clk);
    bus.dato_valid_i = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Watches a quiet line for n cycles: tx high, busy low, no done.
  task automatic check_quiet(input string tag, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.tx_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) bad++;
    end
    chk(tag, bad, 0);
  endtask

  // Called at the first negedge after the accepting edge. Expected line is a
  // 20-bit 8N1 sequence built from the sample; tx is compared every cycle and
  // each data bit is also decoded at mid-bit. Optionally drives an extra strobe
  // at cycle extra_at (FRAME = the done cycle).
  task automatic check_frame(input logic [15:0] d, input int extra_at,
                             input logic [15:0] extra_d, input logic exp_ovr);
    logic [19:0] bits;
    logic [7:0]  by [2];
    logic [7:0]  dec [2];
    int          bad_tx, bad_busy, bad_done, k;
    by[0] = d[15:8];
    by[1] = d[7:0];
    for (int b = 0; b < 2; b++) begin
      bits[b*10] = 1'b0;
      for (int j = 0; j < 8; j++) bits[b*10+1+j] = by[b][j];
      bits[b*10+9] = 1'b1;
    end
    dec[0] = '0;
    dec[1] = '0;
    bad_tx = 0; bad_busy = 0; bad_done = 0;
    chk("start_latency_tx", bus.tx_o, 1'b0);
    for (int i = 0; i <= FRAME; i++) begin
      bus.dato_valid_i = 1'b0;
      if (i == extra_at) begin
        bus.dato_i       = extra_d;
        bus.dato_valid_i = 1'b1;
      end
      if (i < FRAME) begin
        k = i / CPB;
        if (bus.tx_o !== bits[k]) bad_tx++;
        if (bus.busy_o !== 1'b1) bad_busy++;
        if (bus.done_o !== 1'b0) bad_done++;
        if (i % CPB == CPB / 2) begin
          if (k >= 1 && k <= 8)   dec[0][k-1]  = bus.tx_o;
          if (k >= 11 && k <= 18) dec[1][k-11] = bus.tx_o;
        end
        @(negedge clk);
      end else begin
        chk("done_pulse", bus.done_o, 1'b1);
        chk("busy_end", bus.busy_o, 1'b0);
        chk("tx_end", bus.tx_o, 1'b1);
      end
    end
    chk("line_shape", bad_tx, 0);
    chk("busy_hold", bad_busy, 0);
    chk("done_early", bad_done, 0);
    chk("byte0", dec[0], by[0]);
    chk("byte1", dec[1], by[1]);
    chk("overrun", bus.overrun_o, exp_ovr);
  endtask

  initial begin
    logic [15:0] r;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.dato_i       = '0;
    bus.dato_valid_i = 1'b0;
    bus.send_i       = 1'b0;

    // Reset held 100 ns
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_tx", bus.tx_o, 1'b1);
      chk("rst_busy", bus.busy_o, 1'b0);
      if (i % 3 == 0) chk("rst_done", bus.done_o, 1'b0);
      if (i % 3 == 0) chk("rst_ovr", bus.overrun_o, 1'b0);
    end
    rst_n = 1'b1;
    idle_cycles($urandom_range(20, 3));

    // Basic frame
    bus.send_i = 1'b1;
    strobe(16'hA53C);
    check_frame(16'hA53C, -1, 16'h0, 1'b0);
    @(negedge clk);
    chk("done_one_cycle", bus.done_o, 1'b0);

    // send_i low: strobes ignored, no overrun
    bus.send_i = 1'b0;
    strobe(16'h1234);
    check_quiet("nosend_fixed", 20);
    r = 16'($urandom);
    strobe(r);
    check_quiet("nosend_rand", 20);
    chk("nosend_ovr", bus.overrun_o, 1'b0);

    // Strobe while busy: dropped, overrun sticky, no follow-on frame
    bus.send_i = 1'b1;
    strobe(16'hFF9D);
    check_frame(16'hFF9D, 5000, 16'h0001, 1'b1);
    check_quiet("no_extra_frame", 2000);
    chk("ovr_sticky", bus.overrun_o, 1'b1);

    // Reset in bit 5 of byte 0 aborts immediately
    r = 16'($urandom);
    strobe(r);
    idle_cycles(6 * CPB + $urandom_range(800, 50));
    rst_n = 1'b0;
    #1;
    chk("abort_tx", bus.tx_o, 1'b1);
    chk("abort_busy", bus.busy_o, 1'b0);
    chk("abort_ovr", bus.overrun_o, 1'b0);
    idle_cycles(3);
    rst_n = 1'b1;
    check_quiet("after_abort", $urandom_range(40, 5));

    // Clean frame after reset, then back-to-back strobe in the done cycle;
    // send_i drops mid second frame without affecting it.
    strobe(16'h0041);
    check_frame(16'h0041, FRAME, 16'h0355, 1'b0);
    @(negedge clk);
    bus.dato_valid_i = 1'b0;
    bus.send_i       = 1'b0;
    check_frame(16'h0355, -1, 16'h0, 1'b0);
    check_quiet("final_idle", 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
